// File: rtl/data_array_pkg.sv
// Shared types and size helpers for the N-way cache data array and its fill engine.
package data_array_pkg;

   typedef enum logic [1:0] {IDLE, FILL, COMMIT} fill_state_t;

   function automatic int calc_way_w(input int num_ways);
      return (num_ways > 1) ? $clog2(num_ways) : 1;
   endfunction

   function automatic int calc_mask(input int s_offset);
      return 2 ** s_offset;
   endfunction

   function automatic int calc_line(input int s_offset);
      return 8 * (2 ** s_offset);
   endfunction

   function automatic int calc_beats(input int s_offset, input int s_beat);
      return (8 * (2 ** s_offset)) / s_beat;
   endfunction

endpackage

// File: rtl/data_array_fill_buf.sv
// Line-fill assembly buffer: places successive beats into a line and flags the final beat.
module data_array_fill_buf
   import data_array_pkg::*;
#(
   parameter int S_BEAT = 64,
   parameter int BEATS = 4,
   localparam int S_LINE = S_BEAT * BEATS,
   localparam int CNT_W = $clog2(BEATS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              beat_valid,
   input  logic [S_BEAT-1:0] beat_data,
   output logic [S_LINE-1:0] line,
   output logic              last_beat
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   logic [CNT_W-1:0]  cnt_q;
   logic [S_LINE-1:0] line_q;

   // The counter saturates at the last slot; the next fill starts with clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (beat_valid && (cnt_q != LAST_CNT)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         line_q <= '0;
      end else if (beat_valid) begin
         line_q[int'(cnt_q) * S_BEAT +: S_BEAT] <= beat_data;
      end
   end

   assign line      = line_q;
   assign last_beat = (cnt_q == LAST_CNT);

endmodule

// File: rtl/data_array_nway_fill.sv
// N-way cache data array with registered read port and burst line-fill commit.
// Define DATA_ARRAY_BYPASS_EN for write-first read forwarding; otherwise reads are read-first.
module data_array_nway_fill
   import data_array_pkg::*;
#(
   parameter int S_OFFSET = 5,
   parameter int S_INDEX = 3,
   parameter int NUM_WAYS = 2,
   parameter int S_BEAT = 64,
   localparam int S_MASK = calc_mask(S_OFFSET),
   localparam int S_LINE = calc_line(S_OFFSET),
   localparam int WAY_W = calc_way_w(NUM_WAYS),
   localparam int BEATS = calc_beats(S_OFFSET, S_BEAT)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               read,
   input  logic [WAY_W-1:0]   way,
   input  logic [S_INDEX-1:0] index,
   input  logic [S_MASK-1:0]  write_en,
   input  logic [S_LINE-1:0]  datain,
   output logic [S_LINE-1:0]  dataout,
   output logic               rdata_valid,
   input  logic               fill_start,
   input  logic [WAY_W-1:0]   fill_way,
   input  logic [S_INDEX-1:0] fill_index,
   input  logic               fill_beat_valid,
   input  logic [S_BEAT-1:0]  fill_beat_data,
   output logic               fill_busy,
   output logic               fill_done
);

   localparam int SETS = 2 ** S_INDEX;

   fill_state_t        state_q;
   logic [WAY_W-1:0]   fill_way_q;
   logic [S_INDEX-1:0] fill_index_q;
   logic               fill_busy_q;
   logic               fill_done_q;
   logic [S_LINE-1:0]  mem_q [NUM_WAYS][SETS];
   logic [S_LINE-1:0]  dataout_q, dataout_d;
   logic               rdata_valid_q;
   logic [S_LINE-1:0]  rd_stored;
   logic [S_LINE-1:0]  rd_fwd;
   logic [S_LINE-1:0]  fill_line;
   logic               last_beat;
   logic               fb_clear;
   logic               fb_valid;
   logic               commit;

   function automatic logic [S_LINE-1:0] merge_line(input logic [S_LINE-1:0] base,
                                                    input logic [S_LINE-1:0] wdata,
                                                    input logic [S_MASK-1:0] mask);
      logic [S_LINE-1:0] res;
      res = base;
      for (int b = 0; b < S_MASK; b++) begin
         if (mask[b]) res[8*b +: 8] = wdata[8*b +: 8];
      end
      return res;
   endfunction

   assign fb_clear = (state_q == IDLE) && fill_start;
   assign fb_valid = (state_q == FILL) && fill_beat_valid;
   assign commit   = (state_q == COMMIT);

   data_array_fill_buf #(
      .S_BEAT(S_BEAT),
      .BEATS (BEATS)
   ) u_fill_buf (
      .clk       (clk),
      .rst       (rst),
      .clear     (fb_clear),
      .beat_valid(fb_valid),
      .beat_data (fill_beat_data),
      .line      (fill_line),
      .last_beat (last_beat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         fill_way_q   <= '0;
         fill_index_q <= '0;
         fill_busy_q  <= 1'b0;
         fill_done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               fill_done_q <= 1'b0;
               if (fill_start) begin
                  state_q      <= FILL;
                  fill_way_q   <= fill_way;
                  fill_index_q <= fill_index;
                  fill_busy_q  <= 1'b1;
               end
            end
            FILL: begin
               if (fill_beat_valid && last_beat) begin
                  state_q     <= COMMIT;
                  fill_done_q <= 1'b1;
               end
            end
            COMMIT: begin
               state_q     <= IDLE;
               fill_busy_q <= 1'b0;
               fill_done_q <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               fill_busy_q <= 1'b0;
               fill_done_q <= 1'b0;
            end
         endcase
      end
   end

   // CPU-enabled bytes are layered over the fill line so they win on a commit collision.
   always_ff @(posedge clk) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
         for (int s = 0; s < SETS; s++) begin
            if (rst) begin
               mem_q[w][s] <= '0;
            end else begin
               mem_q[w][s] <= merge_line(
                  (commit && (fill_way_q == WAY_W'(w)) && (fill_index_q == S_INDEX'(s)))
                     ? fill_line : mem_q[w][s],
                  datain,
                  ((way == WAY_W'(w)) && (index == S_INDEX'(s))) ? write_en : '0);
            end
         end
      end
   end

   always_comb begin
      rd_stored = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         for (int s = 0; s < SETS; s++) begin
            if ((way == WAY_W'(w)) && (index == S_INDEX'(s))) rd_stored = mem_q[w][s];
         end
      end
   end

`ifdef DATA_ARRAY_BYPASS_EN
   logic commit_rd_hit;
   assign commit_rd_hit = commit && (fill_way_q == way) && (fill_index_q == index);
   assign rd_fwd = merge_line(commit_rd_hit ? fill_line : rd_stored, datain, write_en);
`else
   assign rd_fwd = rd_stored;
`endif

   assign dataout_d = read ? rd_fwd : dataout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         dataout_q     <= '0;
         rdata_valid_q <= 1'b0;
      end else begin
         dataout_q     <= dataout_d;
         rdata_valid_q <= read;
      end
   end

   assign dataout     = dataout_q;
   assign rdata_valid = rdata_valid_q;
   assign fill_busy   = fill_busy_q;
   assign fill_done   = fill_done_q;

endmodule

// File: tb/tb_data_array_nway_fill.sv
// Directed bench for data_array_nway_fill (default parameters: 2 ways, 8 sets, 256-bit lines, 64-bit beats).
module tb_data_array_nway_fill;

   logic         clk;
   logic         rst;
   logic         read;
   logic [0:0]   way;
   logic [2:0]   index;
   logic [31:0]  write_en;
   logic [255:0] datain;
   logic [255:0] dataout;
   logic         rdata_valid;
   logic         fill_start;
   logic [0:0]   fill_way;
   logic [2:0]   fill_index;
   logic         fill_beat_valid;
   logic [63:0]  fill_beat_data;
   logic         fill_busy;
   logic         fill_done;

   int n_chk;
   int n_fail;

   logic [255:0] exp_line;
   logic [255:0] old_line;

   data_array_nway_fill dut (
      .clk            (clk),
      .rst            (rst),
      .read           (read),
      .way            (way),
      .index          (index),
      .write_en       (write_en),
      .datain         (datain),
      .dataout        (dataout),
      .rdata_valid    (rdata_valid),
      .fill_start     (fill_start),
      .fill_way       (fill_way),
      .fill_index     (fill_index),
      .fill_beat_valid(fill_beat_valid),
      .fill_beat_data (fill_beat_data),
      .fill_busy      (fill_busy),
      .fill_done      (fill_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1;
      read = 1'b0;
      way = '0;
      index = '0;
      write_en = '0;
      datain = '0;
      fill_start = 1'b0;
      fill_way = '0;
      fill_index = '0;
      fill_beat_valid = 1'b0;
      fill_beat_data = '0;
      @(negedge clk);
      step();
      step();
      chk("rst_dataout", dataout, '0);
      chk("rst_rvalid", {255'd0, rdata_valid}, 256'd0);
      chk("rst_busy", {255'd0, fill_busy}, 256'd0);
      chk("rst_done", {255'd0, fill_done}, 256'd0);
      rst = 1'b0;

      // Read of an untouched line after reset
      read = 1'b1; way = 1'b1; index = 3'd5;
      step();
      chk("rd1_valid", {255'd0, rdata_valid}, 256'd1);
      chk("rd1_data", dataout, '0);
      read = 1'b0;
      step();
      chk("rd1_valid_low", {255'd0, rdata_valid}, 256'd0);

      // Partial byte write, bytes 4..31 carry a pattern that must be masked off
      way = 1'b0; index = 3'd2; write_en = 32'h0000_000F;
      datain = {{28{8'h55}}, {4{8'hAA}}};
      step();
      write_en = '0; read = 1'b1;
      step();
      chk("wr_partial", dataout, {{28{8'h00}}, {4{8'hAA}}});
      way = 1'b1;
      step();
      chk("wr_other_way", dataout, '0);

      // Same-cycle read and write of byte 4
      way = 1'b0; write_en = 32'h0000_0010;
      datain = {{27{8'h55}}, 8'h77, {4{8'h55}}};
      step();
`ifdef DATA_ARRAY_BYPASS_EN
      chk("rw_same_cycle", dataout, {{27{8'h00}}, 8'h77, {4{8'hAA}}});
`else
      chk("rw_same_cycle", dataout, {{28{8'h00}}, {4{8'hAA}}});
`endif
      write_en = '0;
      step();
      chk("rw_after", dataout, {{27{8'h00}}, 8'h77, {4{8'hAA}}});
      read = 1'b0;

      // Stray beat while idle must not disturb the next fill
      fill_beat_valid = 1'b1; fill_beat_data = 64'hDEAD_BEEF_DEAD_BEEF;
      step();
      chk("idle_beat_busy", {255'd0, fill_busy}, 256'd0);

      // Fill way1/index3 with stalls between beats 1 and 2
      fill_beat_valid = 1'b0;
      fill_start = 1'b1; fill_way = 1'b1; fill_index = 3'd3;
      step();
      fill_start = 1'b0;
      chk("fill_busy_start", {255'd0, fill_busy}, 256'd1);
      fill_beat_valid = 1'b1; fill_beat_data = 64'h1111_1111_1111_1111;
      step();
      fill_beat_data = 64'h2222_2222_2222_2222;
      step();
      chk("fill_done_mid", {255'd0, fill_done}, 256'd0);
      fill_beat_valid = 1'b0;
      read = 1'b1; way = 1'b0; index = 3'd2;
      step();
      chk("fill_stall_busy", {255'd0, fill_busy}, 256'd1);
      chk("fill_cpu_rd", dataout, {{27{8'h00}}, 8'h77, {4{8'hAA}}});
      read = 1'b0;
      step();
      chk("fill_stall2_busy", {255'd0, fill_busy}, 256'd1);
      fill_beat_valid = 1'b1; fill_beat_data = 64'h3333_3333_3333_3333;
      step();
      fill_beat_data = 64'h4444_4444_4444_4444;
      step();
      fill_beat_valid = 1'b0;
      chk("fill_done_pulse", {255'd0, fill_done}, 256'd1);
      chk("fill_busy_commit", {255'd0, fill_busy}, 256'd1);
      step();
      chk("fill_done_clear", {255'd0, fill_done}, 256'd0);
      chk("fill_busy_clear", {255'd0, fill_busy}, 256'd0);
      read = 1'b1; way = 1'b1; index = 3'd3;
      step();
      old_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      chk("fill_line", dataout, old_line);
      read = 1'b0;

      // Refill same line; fill_start to index 6 mid-fill is ignored; CPU collides in COMMIT
      fill_start = 1'b1; fill_way = 1'b1; fill_index = 3'd3;
      step();
      fill_index = 3'd6;
      fill_beat_valid = 1'b1; fill_beat_data = 64'hAAAA_AAAA_AAAA_AAAA;
      step();
      fill_start = 1'b0;
      fill_beat_data = 64'hBBBB_BBBB_BBBB_BBBB;
      step();
      fill_beat_data = 64'hCCCC_CCCC_CCCC_CCCC;
      step();
      fill_beat_data = 64'hDDDD_DDDD_DDDD_DDDD;
      step();
      fill_beat_valid = 1'b0;
      chk("coll_done", {255'd0, fill_done}, 256'd1);
      read = 1'b1; way = 1'b1; index = 3'd3;
      write_en = 32'h0000_0001; datain = {{31{8'hFF}}, 8'h5A};
      step();
      exp_line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AA5A};
`ifdef DATA_ARRAY_BYPASS_EN
      chk("coll_rd", dataout, exp_line);
`else
      chk("coll_rd", dataout, old_line);
`endif
      write_en = '0;
      step();
      chk("coll_stored", dataout, exp_line);
      index = 3'd6;
      step();
      chk("ignored_start", dataout, '0);
      read = 1'b0;

      // Reset after two beats aborts the fill
      fill_start = 1'b1; fill_way = 1'b0; fill_index = 3'd7;
      step();
      fill_start = 1'b0;
      fill_beat_valid = 1'b1; fill_beat_data = 64'h9999_9999_9999_9999;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", {255'd0, fill_busy}, 256'd0);
      chk("abort_done", {255'd0, fill_done}, 256'd0);
      step();
      step();
      fill_beat_valid = 1'b0;
      chk("abort_no_done", {255'd0, fill_done}, 256'd0);
      chk("abort_busy_later", {255'd0, fill_busy}, 256'd0);
      read = 1'b1; way = 1'b0; index = 3'd7;
      step();
      chk("abort_line", dataout, '0);
      way = 1'b1; index = 3'd3;
      step();
      chk("rst_clears_mem", dataout, '0);
      read = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/data_array_nway_fill.md
Name: data_array_nway_fill

Overview:
- Parametrised N-way cache data array. Successor to the single-way, combinational-read byte-enable array.
- Adds way selection, a registered read port with a valid strobe, and write-first forwarding.
- Adds a burst line-fill engine that assembles a full line from memory beats and commits it in one cycle.
- Sits between the cache controller (CPU hit path) and the memory/arbiter fill path.

Parameters:
S_OFFSET, 5, log2 of line size in bytes; S_MASK = 2**S_OFFSET, S_LINE = 8*S_MASK.
S_INDEX, 3, log2 of sets per way.
NUM_WAYS, 2, number of ways (power of two, >=1); WAY_W = max(1, $clog2(NUM_WAYS)).
S_BEAT, 64, fill beat width in bits; must divide S_LINE; BEATS = S_LINE/S_BEAT (>=2).

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous active-high reset.
read  input  1  read request for (way, index).
way  input  WAY_W  way for CPU read/write.
index  input  S_INDEX  set for CPU read/write.
write_en  input  S_MASK  per-byte CPU write enable.
datain  input  S_LINE  CPU write data.
dataout  output  S_LINE  registered read data.
rdata_valid  output  1  high the cycle after an accepted read.
fill_start  input  1  begin a line fill.
fill_way  input  WAY_W  target way for fill.
fill_index  input  S_INDEX  target set for fill.
fill_beat_valid  input  1  fill_beat_data valid this cycle.
fill_beat_data  input  S_BEAT  beat payload; beat k lands at bits [k*S_BEAT +: S_BEAT].
fill_busy  output  1  fill engine not IDLE.
fill_done  output  1  one-cycle pulse on commit cycle.

Behaviour:
- Reset (sync, rst=1 at edge):
  - dataout=0, rdata_valid=0, fill_busy=0, fill_done=0.
  - FSM to IDLE, beat counter=0, all storage zeroed.
  - Reset mid-fill aborts the fill; no commit, no fill_done.
- CPU write: each byte i with write_en[i]=1 updates storage[way][index] byte i at the edge; other bytes unchanged.
- CPU read: latency 1.
  - read=1 at edge N -> dataout holds the line and rdata_valid=1 during cycle N+1.
  - read=0 -> rdata_valid=0 and dataout holds its previous value.
- Same-cycle read and write to the same way/index: write-first per byte; written bytes return datain, others return stored data.
- Fill FSM states: IDLE, FILL, COMMIT.
  - IDLE -> FILL on fill_start: capture fill_way/fill_index, clear beat counter and line buffer.
  - FILL: each fill_beat_valid stores the beat at the counter position and increments the counter. The beat at counter = BEATS-1 moves to COMMIT. Beats without valid are stalls; no timeout.
  - COMMIT (one cycle): write the whole buffer to storage[fill_way][fill_index], pulse fill_done, return to IDLE.
- fill_busy=1 in FILL and COMMIT. fill_start while busy is ignored. fill_beat_valid in IDLE or COMMIT is ignored.
- Simultaneous CPU write to the fill line in the COMMIT cycle: the CPU-enabled bytes win; remaining bytes take fill data.
- Read of the fill line in the COMMIT cycle returns the merged post-commit line.
- CPU reads and writes to other lines proceed normally during FILL; the fill never stalls the CPU port.
- The beat counter is $clog2(BEATS) bits and never wraps past BEATS-1.

Optional Feature:
DATA_ARRAY_BYPASS_EN
- Defined: write-first forwarding as above for both CPU writes and the fill commit.
- Not defined: read-first; a same-cycle read returns the pre-write stored line. This shortens the read-path mux for timing.
- Storage update behaviour is identical in both builds.

Decomposition:
- Package data_array_pkg:
  - fill_state_t enum {IDLE, FILL, COMMIT}.
  - Helper localparams/functions deriving S_MASK, S_LINE, BEATS, WAY_W from the parameters.
- Sub-module data_array_fill_buf: beat counter plus line buffer.
  - Inputs: clear, beat_valid, beat_data.
  - Outputs: line, last_beat.
  - The FSM stays in the top module.

Test Plan:
- Reset, then read way1/index5 -> next cycle rdata_valid=1, dataout=0; with read low the cycle after, rdata_valid=0.
- Write way0/index2 with write_en=32'h0000_000F, datain bytes 0..3=8'hAA, then read -> bytes 0..3=8'hAA, bytes 4..31=0; way1/index2 unchanged (0).
- Fill way1/index3 with 4 beats (S_BEAT=64) of 64'h1111..., 2222..., 3333..., 4444..., with 2 idle stall cycles between beats 1 and 2 -> fill_busy high throughout, fill_done one pulse, then read shows beat0 in bits[63:0], beat3 in bits[255:192].
- COMMIT-cycle collision: CPU write to way1/index3 byte0=8'h5A plus same-cycle read -> stored byte0=8'h5A, other bytes from fill. With DATA_ARRAY_BYPASS_EN, dataout byte0=8'h5A; without it, dataout is the old line.
- fill_start asserted during FILL with a different index -> ignored, original target committed. rst asserted after 2 beats -> fill_busy=0, no fill_done, target line stays 0.
